gpio_ctrl: RTL and testbench
============================

# gpio_ctrl

Parametrised memory-mapped GPIO controller for the multicycle MIPS data bus. It replaces the single write-only output latch with a register bank behind one 32-byte window: per-bit direction, atomic set/clear/toggle, synchronised inputs, and an optional rising-edge interrupt. It decodes the CPU `Address`/`Data` bus and drives the board pins and a level interrupt to the core.

## Interface
- `BASE_ADDR`, 32'h10010020: window base; must be 32-byte aligned.
- `PORT_WIDTH`, 8: number of pins, 1..32.
- `SYNC_STAGES`, 2: input synchroniser depth, minimum 2.
- `clk`  in  1  system clock; all state on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `Address`  in  32  CPU byte address.
- `Data`  in  32  CPU write data.
- `MemWrite`  in  1  write strobe, sampled on posedge.
- `ReadData`  out  32  combinational read data.
- `GPIO_PORT_IN`  in  PORT_WIDTH  asynchronous pin inputs.
- `GPIO_PORT_OUT`  out  PORT_WIDTH  output register.
- `GPIO_PORT_OE`  out  PORT_WIDTH  direction; 1 = drive.
- `irq`  out  1  level interrupt.

## Operation
- Hit when `Address[31:5]==BASE_ADDR[31:5]`. Register offset is `Address[4:2]`; `Address[1:0]` is ignored. Only `Data[PORT_WIDTH-1:0]` is used.
- Register map:
  - 0x00 OUT: R/W.
  - 0x04 DIR: R/W; drives `GPIO_PORT_OE`.
  - 0x08 IN: RO; synchronised pins.
  - 0x0C SET: WO; OUT |= D.
  - 0x10 CLR: WO; OUT &= ~D.
  - 0x14 TGL: WO; OUT ^= D.
  - 0x18 IE: R/W.
  - 0x1C IS: R, write-1-to-clear.
- Writes to read-only offsets are ignored. WO offsets read as 0.
- Reads of a non-hit address return 0. Read bits above PORT_WIDTH are 0.
- Edge detect:
  - `in_prev` registers the synchroniser output.
  - `rise = sync & ~in_prev & ~DIR`; output-configured bits never flag.
  - IS bit sets on `rise`.
- IS set/clear priority: a W1C write in the same cycle as a new `rise` on that bit leaves the bit set (set wins).
- `irq = |(IS & IE)`, driven from flops only; no combinational path from `Address`/`Data`.
- Reset clears OUT, DIR, IE, IS, the synchroniser and `in_prev`:
  - `GPIO_PORT_OUT=0`, `GPIO_PORT_OE=0` (all inputs), `irq=0`.
  - `ReadData` follows the cleared registers.

## Timing
- Write: committed on the posedge where `MemWrite`=1 and the address hits. Visible on `GPIO_PORT_OUT`/`GPIO_PORT_OE`/`ReadData` after that edge (1-cycle latency).
- Read: combinational from the current register state, same cycle as `Address`.
- Input latency: a pin change is visible in IN after SYNC_STAGES posedges.
- IS sets one posedge later, and `irq` asserts in the same cycle IS sets.
- `irq` deasserts the cycle after the W1C or IE-clear write.
- Asynchronous reset mid-write aborts the write, and all state goes to reset values immediately. The first edge after deassertion cannot generate `rise`, because `in_prev` and the synchroniser are both 0 and a held-high pin needs SYNC_STAGES edges.

## Configuration
- `GPIO_IRQ_EN` defined:
  - IE, IS, edge detect and `irq` are present as above.
- `GPIO_IRQ_EN` undefined:
  - No IE/IS/`in_prev` flops.
  - Offsets 0x18/0x1C read 0 and ignore writes.
  - `irq` is tied to 0.
  - All other behaviour is identical.

## Structure
- `gpio_pkg` holds:
  - the offset localparams (OFS_OUT=3'd0 … OFS_IS=3'd7);
  - the `gpio_reg_e` enum over them;
  - the default base-address constant.
- Sub-module `gpio_sync`: parametrised on WIDTH and STAGES, async active-low reset, one instance for `GPIO_PORT_IN`.
- Top level contains decode, register bank, edge detect and read mux.

## Test plan
- Reset: assert `rst`=0 mid-run. Expect `GPIO_PORT_OUT`=0, `GPIO_PORT_OE`=0, `irq`=0, and a read of 0x10010020 returns 0.
- Atomic ops:
  - write OUT=0xA5 → 0xA5;
  - SET 0x0F → 0xAF;
  - CLR 0x81 → 0x2E;
  - TGL 0xFF → 0xD1.
  - Each value appears one cycle after the write.
- Decode miss: write 0x55 to 0x10010040 → OUT unchanged and `ReadData`=0. Write 0x55 to 0x10010022 (offset 0, low bits ignored) → OUT=0x55.
- Input path: DIR=0, drive pin 3 high → IN reads 0x08 after exactly 2 edges (SYNC_STAGES=2). With DIR[3]=1, no IS flag is raised.
- Interrupt (`GPIO_IRQ_EN`):
  - IE=0x08, pin 3 rises → IS=0x08 and `irq`=1 one edge after IN updates;
  - W1C 0x08 → `irq`=0 next cycle;
  - W1C coincident with a new rise → IS stays 0x08.
- No `GPIO_IRQ_EN`: the same stimulus leaves `irq`=0, and reads of 0x18/0x1C return 0.

Source files
------------

// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants for the memory-mapped GPIO controller.
//   - bus and offset widths
//   - register offsets within the 32-byte window (word index Address[4:2])
//   - gpio_reg_e enum over those offsets
//   - default window base address
package gpio_pkg;

    localparam int unsigned BUS_W = 32;
    localparam int unsigned OFS_W = 3;

    localparam logic [OFS_W-1:0] OFS_OUT = 3'd0;
    localparam logic [OFS_W-1:0] OFS_DIR = 3'd1;
    localparam logic [OFS_W-1:0] OFS_IN  = 3'd2;
    localparam logic [OFS_W-1:0] OFS_SET = 3'd3;
    localparam logic [OFS_W-1:0] OFS_CLR = 3'd4;
    localparam logic [OFS_W-1:0] OFS_TGL = 3'd5;
    localparam logic [OFS_W-1:0] OFS_IE  = 3'd6;
    localparam logic [OFS_W-1:0] OFS_IS  = 3'd7;

    // Every 3-bit value maps to a register, so a cast from Address[4:2] is total.
    typedef enum logic [OFS_W-1:0] {
        REG_OUT = OFS_OUT,
        REG_DIR = OFS_DIR,
        REG_IN  = OFS_IN,
        REG_SET = OFS_SET,
        REG_CLR = OFS_CLR,
        REG_TGL = OFS_TGL,
        REG_IE  = OFS_IE,
        REG_IS  = OFS_IS
    } gpio_reg_e;

    localparam logic [BUS_W-1:0] GPIO_DEFAULT_BASE = 32'h1001_0020;

endpackage

// File: rtl/gpio_ctrl_if.sv
// gpio_ctrl_if: CPU data-bus slice seen by the GPIO controller.
//   Address   CPU byte address
//   Data      CPU write data
//   MemWrite  write strobe, sampled on posedge
//   ReadData  combinational read data from the slave
// Modports: master (CPU side), slave (peripheral side).
interface gpio_ctrl_if;
    import gpio_pkg::*;

    logic [BUS_W-1:0] Address;
    logic [BUS_W-1:0] Data;
    logic             MemWrite;
    logic [BUS_W-1:0] ReadData;

    modport master (
        output Address,
        output Data,
        output MemWrite,
        input  ReadData
    );

    modport slave (
        input  Address,
        input  Data,
        input  MemWrite,
        output ReadData
    );

endinterface

// File: rtl/gpio_sync.sv
// gpio_sync: multi-flop synchroniser for asynchronous pin inputs.
// Ports:
//   clk    sampling clock
//   rst_n  asynchronous active-low reset, clears every stage
//   d      asynchronous inputs (WIDTH bits)
//   q      synchronised outputs, STAGES posedges after d
// Parameters: WIDTH (bits), STAGES (depth, minimum 2).
module gpio_sync #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    // Shift chain: stage 0 samples the pins, the last stage is the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], d};
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO controller behind a 32-byte window.
// Registers (offset = Address[4:2]*4): OUT, DIR, IN (RO), SET/CLR/TGL (WO),
// IE, IS (write-1-to-clear).
// Optional feature macro: GPIO_IRQ_EN (enables IE/IS, rising-edge detect, irq).
// Ports:
//   clk            system clock, all state on posedge
//   rst            asynchronous active-low reset
//   bus            gpio_ctrl_if.slave (Address, Data, MemWrite, ReadData)
//   GPIO_PORT_IN   asynchronous pin inputs
//   GPIO_PORT_OUT  output register
//   GPIO_PORT_OE   direction, 1 = drive
//   irq            level interrupt, driven from flops only
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter logic [BUS_W-1:0] BASE_ADDR   = GPIO_DEFAULT_BASE,
    parameter int unsigned      PORT_WIDTH  = 8,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    gpio_ctrl_if.slave            bus,
    input  logic [PORT_WIDTH-1:0] GPIO_PORT_IN,
    output logic [PORT_WIDTH-1:0] GPIO_PORT_OUT,
    output logic [PORT_WIDTH-1:0] GPIO_PORT_OE,
    output logic                  irq
);

    localparam int unsigned PW = PORT_WIDTH;

    // ---------------------------------------------------------------
    // Decode
    // ---------------------------------------------------------------
    logic          hit;
    logic          wr;
    gpio_reg_e     ofs;
    logic [PW-1:0] wdata;

    assign hit   = (bus.Address[BUS_W-1:5] == BASE_ADDR[BUS_W-1:5]);
    assign ofs   = gpio_reg_e'(bus.Address[4:2]);
    assign wdata = bus.Data[PW-1:0];
    assign wr    = bus.MemWrite & hit;

    // Byte-lane bits and data bits above the port width carry no meaning here.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.Address[1:0], bus.Data};

    // ---------------------------------------------------------------
    // Input synchroniser
    // ---------------------------------------------------------------
    logic [PW-1:0] in_sync;

    gpio_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (GPIO_PORT_IN),
        .q     (in_sync)
    );

    // ---------------------------------------------------------------
    // OUT / DIR register bank with atomic set/clear/toggle
    // ---------------------------------------------------------------
    logic [PW-1:0] out_q;
    logic [PW-1:0] dir_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= '0;
            dir_q <= '0;
        end else if (wr) begin
            case (ofs)
                REG_OUT: out_q <= wdata;
                REG_DIR: dir_q <= wdata;
                REG_SET: out_q <= out_q | wdata;
                REG_CLR: out_q <= out_q & ~wdata;
                REG_TGL: out_q <= out_q ^ wdata;
                default: ;
            endcase
        end
    end

    assign GPIO_PORT_OUT = out_q;
    assign GPIO_PORT_OE  = dir_q;

`ifdef GPIO_IRQ_EN
    // ---------------------------------------------------------------
    // Rising-edge detect and interrupt status
    // ---------------------------------------------------------------
    logic [PW-1:0] in_prev_q;
    logic [PW-1:0] ie_q;
    logic [PW-1:0] is_q;
    logic [PW-1:0] rise;
    logic [PW-1:0] w1c;

    // Pins configured as outputs never raise a status bit.
    assign rise = in_sync & ~in_prev_q & ~dir_q;
    assign w1c  = (wr && (ofs == REG_IS)) ? wdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_prev_q <= '0;
            ie_q      <= '0;
            is_q      <= '0;
        end else begin
            in_prev_q <= in_sync;
            if (wr && (ofs == REG_IE)) begin
                ie_q <= wdata;
            end
            // A new rise overrides a same-cycle write-1-to-clear.
            is_q <= (is_q & ~w1c) | rise;
        end
    end

    assign irq = |(is_q & ie_q);
`else
    assign irq = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Read mux: combinational, zero for misses and write-only offsets
    // ---------------------------------------------------------------
    logic [PW-1:0] rdata;

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (ofs)
                REG_OUT: rdata = out_q;
                REG_DIR: rdata = dir_q;
                REG_IN:  rdata = in_sync;
`ifdef GPIO_IRQ_EN
                REG_IE:  rdata = ie_q;
                REG_IS:  rdata = is_q;
`endif
                default: rdata = '0;
            endcase
        end
    end

    assign bus.ReadData = BUS_W'(rdata);

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: directed scoreboard bench for gpio_ctrl (PORT_WIDTH=8,
// SYNC_STAGES=2). Stimulus pushes expected values tagged with the cycle they
// are due; a monitor pops and compares them on the falling edge.
module tb_gpio_ctrl;

    localparam logic [31:0] A_OUT  = 32'h1001_0020;
    localparam logic [31:0] A_DIR  = 32'h1001_0024;
    localparam logic [31:0] A_IN   = 32'h1001_0028;
    localparam logic [31:0] A_SET  = 32'h1001_002C;
    localparam logic [31:0] A_CLR  = 32'h1001_0030;
    localparam logic [31:0] A_TGL  = 32'h1001_0034;
    localparam logic [31:0] A_IE   = 32'h1001_0038;
    localparam logic [31:0] A_IS   = 32'h1001_003C;
    localparam logic [31:0] A_MISS = 32'h1001_0040;

`ifdef GPIO_IRQ_EN
    localparam logic [31:0] X8  = 32'h0000_0008;
    localparam logic [31:0] XIR = 32'h0000_0001;
`else
    localparam logic [31:0] X8  = 32'h0000_0000;
    localparam logic [31:0] XIR = 32'h0000_0000;
`endif

    typedef enum logic [1:0] {K_OUT, K_OE, K_IRQ, K_RD} kind_e;

    typedef struct {
        int unsigned  due;
        kind_e        kind;
        logic [31:0]  exp;
        logic [127:0] name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  pins = 8'h00;
    logic [7:0]  port_out;
    logic [7:0]  port_oe;
    logic        irq;

    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    exp_t        sb[$];

    gpio_ctrl_if bus ();

    gpio_ctrl #(
        .BASE_ADDR   (32'h1001_0020),
        .PORT_WIDTH  (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .GPIO_PORT_IN  (pins),
        .GPIO_PORT_OUT (port_out),
        .GPIO_PORT_OE  (port_oe),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every entry due in the current cycle.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                case (e.kind)
                    K_OUT:   act = {24'h0, port_out};
                    K_OE:    act = {24'h0, port_oe};
                    K_IRQ:   act = {31'h0, irq};
                    default: act = bus.ReadData;
                endcase
                checks = checks + 1;
                if (e.due != cyc) begin
                    errors = errors + 1;
                    $display("FAIL %0s stale entry due %0d seen %0d", e.name, e.due, cyc);
                end else if (act !== e.exp) begin
                    errors = errors + 1;
                    $display("FAIL %0s actual %h required %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input kind_e kind, input logic [31:0] exp, input logic [127:0] name);
        exp_t e;
        e.due  = cyc;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.Address  = a;
        bus.Data     = d;
        bus.MemWrite = 1'b1;
        tick();
        bus.MemWrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input logic [127:0] name);
        bus.Address = a;
        chk(K_RD, exp, name);
        tick();
    endtask

    task automatic settle_pin3(input logic v);
        pins[3] = v;
        tick();
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Address  = 32'h0;
        bus.Data     = 32'h0;
        bus.MemWrite = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Reset state
        chk(K_OUT, 32'h00, "rst_out");
        chk(K_OE,  32'h00, "rst_oe");
        chk(K_IRQ, 32'h00, "rst_irq");
        rd(A_OUT, 32'h0, "rst_rd");

        // Atomic ops, with one-cycle write latency on SET
        wr(A_OUT, 32'hA5);
        chk(K_OUT, 32'hA5, "out_a5");
        bus.Address  = A_SET;
        bus.Data     = 32'h0F;
        bus.MemWrite = 1'b1;
        chk(K_OUT, 32'hA5, "set_pre");
        tick();
        bus.MemWrite = 1'b0;
        chk(K_OUT, 32'hAF, "set_0f");
        wr(A_CLR, 32'h81);
        chk(K_OUT, 32'h2E, "clr_81");
        wr(A_TGL, 32'hFF);
        chk(K_OUT, 32'hD1, "tgl_ff");
        rd(A_OUT, 32'hD1, "rd_out");
        rd(A_SET, 32'h0, "rd_wo");

        // Decode miss and ignored byte-lane bits
        wr(A_MISS, 32'h55);
        chk(K_OUT, 32'hD1, "miss_out");
        rd(A_MISS, 32'h0, "miss_rd");
        wr(32'h1001_0022, 32'h55);
        chk(K_OUT, 32'h55, "lowbits_out");

        // Direction and read-only IN
        wr(A_DIR, 32'hF0);
        chk(K_OE, 32'hF0, "dir_f0");
        rd(A_DIR, 32'hF0, "rd_dir");
        wr(A_DIR, 32'h00);
        chk(K_OE, 32'h00, "dir_00");
        wr(A_IN, 32'hFF);
        rd(A_IN, 32'h0, "in_ro");

        // Interrupt enable
        wr(A_IE, 32'h08);
        rd(A_IE, X8, "rd_ie");

        // Input path: IN updates after exactly two edges, IS one edge later
        bus.Address = A_IN;
        pins[3] = 1'b1;
        chk(K_RD, 32'h0, "in_e0");
        tick();
        chk(K_RD, 32'h0, "in_e1");
        tick();
        chk(K_RD, 32'h8, "in_e2");
        chk(K_IRQ, 32'h0, "irq_pre");
        tick();
        chk(K_IRQ, XIR, "irq_set");
        rd(A_IS, X8, "is_set");

        // W1C deasserts irq the next cycle
        wr(A_IS, 32'h08);
        chk(K_IRQ, 32'h0, "irq_w1c");
        rd(A_IS, 32'h0, "is_w1c");

        // IE clear deasserts irq, IE set reasserts it
        settle_pin3(1'b0);
        settle_pin3(1'b1);
        chk(K_IRQ, XIR, "irq_set2");
        wr(A_IE, 32'h00);
        chk(K_IRQ, 32'h0, "irq_ieclr");
        wr(A_IE, 32'h08);
        chk(K_IRQ, XIR, "irq_ieset");

        // W1C coincident with a new rise: set wins
        settle_pin3(1'b0);
        pins[3] = 1'b1;
        tick();
        tick();
        wr(A_IS, 32'h08);
        chk(K_IRQ, XIR, "irq_coinc");
        rd(A_IS, X8, "is_coinc");
        wr(A_IS, 32'h08);
        rd(A_IS, 32'h0, "is_clr2");

        // Output-configured pin never flags
        settle_pin3(1'b0);
        wr(A_DIR, 32'h08);
        pins[3] = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk(K_IRQ, 32'h0, "irq_dirout");
        rd(A_IS, 32'h0, "is_dirout");
        rd(A_IN, 32'h8, "in_dirout");
        wr(A_DIR, 32'h00);

        // Asynchronous reset in the middle of a write
        settle_pin3(1'b0);
        settle_pin3(1'b1);
        wr(A_OUT, 32'hFF);
        wr(A_DIR, 32'hF0);
        chk(K_IRQ, XIR, "irq_prerst");
        bus.Address  = A_OUT;
        bus.Data     = 32'h33;
        bus.MemWrite = 1'b1;
        #1;
        rst = 1'b0;
        chk(K_OUT, 32'h0, "rst2_out");
        chk(K_OE,  32'h0, "rst2_oe");
        chk(K_IRQ, 32'h0, "rst2_irq");
        tick();
        bus.MemWrite = 1'b0;
        rd(A_OUT, 32'h0, "rst2_rd");
        rst = 1'b1;
        chk(K_OUT, 32'h0, "rel_out");
        bus.Address = A_IS;
        tick();
        chk(K_RD, 32'h0, "is_rel1");
        tick();
        chk(K_RD, 32'h0, "is_rel2");
        tick();
        chk(K_RD, X8, "is_rel3");
        chk(K_IRQ, 32'h0, "irq_rel3");
        tick();

        // Unreachable offsets without the interrupt option
        wr(A_IE, 32'hFF);
        rd(A_IE, (XIR != 0) ? 32'hFF : 32'h0, "rd_ie_ff");

        tick();
        tick();
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL sb_drain actual %0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
